// File: rtl/ysyx_22050039_pipe_reg.sv
// Valid/ready pipeline register with optional skid entry.
// SKID=1 sustains one beat per cycle; SKID=0 passes one beat every two cycles.
module ysyx_22050039_pipe_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q, rdy_d;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer   = in_valid && rdy_q;
  assign out_xfer  = (state_q != EMPTY) && out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign count     = state_q;

  // Next state and data loads; flush empties without touching data.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end else if (in_xfer && SKID) begin
            skid_d  = in_data;
            state_d = TWO;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    if (SKID) rdy_d = (state_d != TWO);
    else      rdy_d = (state_d == EMPTY);
  end

  // State, data and registered in_ready; reset beats flush and transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050039_pipe_reg.sv
// Bench for ysyx_22050039_pipe_reg: SKID=1 and SKID=0 instances
// driven in parallel, checked against a queue model every cycle.
module tb_ysyx_22050039_pipe_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        a_ir, a_ov, b_ir, b_ov;
  logic [31:0] a_od, b_od;
  logic [1:0]  a_cnt, b_cnt;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  ysyx_22050039_pipe_reg #(
    .WIDTH(32), .RESET_VAL(32'h5), .SKID(1'b1)
  ) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ir),
    .in_data(in_data), .out_valid(a_ov), .out_ready(out_ready),
    .out_data(a_od), .flush(flush), .count(a_cnt)
  );

  ysyx_22050039_pipe_reg #(
    .WIDTH(32), .RESET_VAL(32'h0), .SKID(1'b0)
  ) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ir),
    .in_data(in_data), .out_valid(b_ov), .out_ready(out_ready),
    .out_data(b_od), .flush(flush), .count(b_cnt)
  );

  // Model: per instance, a list of held beats (front = on output)
  // plus the last value shown on out_data.
  logic [31:0] mb [2][2];
  int          mn [2] = '{0, 0};
  logic [31:0] ml [2] = '{32'h0, 32'h0};
  bit          mskid [2] = '{1'b1, 1'b0};
  logic [31:0] mrv [2] = '{32'h5, 32'h0};

  function automatic bit e_ir(int k);
    return mskid[k] ? (mn[k] < 2) : (mn[k] == 0);
  endfunction

  function automatic logic [31:0] e_od(int k);
    return (mn[k] > 0) ? mb[k][0] : ml[k];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit ox, ix;
      if (mn[k] > 0) ml[k] = mb[k][0];
      if (rst) begin
        mn[k] = 0;
        ml[k] = mrv[k];
      end else if (flush) begin
        mn[k] = 0;
      end else begin
        ox = (mn[k] > 0) && out_ready;
        ix = in_valid && e_ir(k);
        if (ox) begin
          mb[k][0] = mb[k][1];
          mn[k] = mn[k] - 1;
        end
        if (ix) begin
          mb[k][mn[k]] = in_data;
          mn[k] = mn[k] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("a_in_ready", 32'(a_ir), 32'(e_ir(0)));
      chk("a_out_valid", 32'(a_ov), 32'(mn[0] > 0));
      chk("a_out_data", a_od, e_od(0));
      chk("a_count", 32'(a_cnt), 32'(mn[0]));
      chk("b_in_ready", 32'(b_ir), 32'(e_ir(1)));
      chk("b_out_valid", 32'(b_ov), 32'(mn[1] > 0));
      chk("b_out_data", b_od, e_od(1));
      chk("b_count", 32'(b_cnt), 32'(mn[1]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    step();
    mon_en = 1'b1;
    chk("rst_a_count", 32'(a_cnt), 32'd0);
    chk("rst_a_valid", 32'(a_ov), 32'd0);
    chk("rst_a_ready", 32'(a_ir), 32'd1);
    chk("rst_a_data", a_od, 32'h5);
    chk("rst_b_data", b_od, 32'h0);
    rst = 1'b0;

    // One-cycle latency
    in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b1;
    step();
    chk("lat_valid", 32'(a_ov), 32'd1);
    chk("lat_data", a_od, 32'hA5);
    chk("lat_count", 32'(a_cnt), 32'd1);
    in_valid = 1'b0;
    step();
    chk("hold_count", 32'(a_cnt), 32'd0);
    chk("hold_data", a_od, 32'hA5);

    // Fill skid, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    step();
    in_data = 32'h22;
    step();
    chk("two_count", 32'(a_cnt), 32'd2);
    chk("two_ready", 32'(a_ir), 32'd0);
    chk("b_one_ready", 32'(b_ir), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("drain_first", a_od, 32'h11);
    step();
    chk("drain_second", a_od, 32'h22);
    chk("drain_count", 32'(a_cnt), 32'd1);
    step();
    chk("drain_empty", 32'(a_cnt), 32'd0);

    // Full-throughput stream on SKID=1
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      step();
      chk("stream_data", a_od, 32'(i));
      chk("stream_count", 32'(a_cnt), 32'd1);
    end
    in_valid = 1'b0;
    step();
    step();

    // Half-throughput stream on SKID=0
    for (int c = 0; c < 32; c++) begin
      in_valid = 1'b1; out_ready = 1'b1; in_data = 32'(c / 2);
      chk("half_ready", 32'(b_ir), 32'((c % 2) == 0));
      chk("half_valid", 32'(b_ov), 32'((c % 2) == 1));
      if (c % 2 == 1) chk("half_data", b_od, 32'(c / 2));
      step();
    end
    in_valid = 1'b0;
    step();
    step();

    // Flush from TWO with a beat presented
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h33;
    step();
    in_data = 32'h44;
    step();
    chk("fl_pre_count", 32'(a_cnt), 32'd2);
    flush = 1'b1; in_data = 32'h55;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_count", 32'(a_cnt), 32'd0);
    chk("fl_valid", 32'(a_ov), 32'd0);
    chk("fl_ready", 32'(a_ir), 32'd1);
    chk("fl_data", a_od, 32'h33);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_gone", 32'(a_ov), 32'd0);
    end

    // Reset and flush together while in ONE
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h66;
    step();
    chk("rf_pre", a_od, 32'h66);
    in_valid = 1'b0; rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    chk("rf_data", a_od, 32'h5);
    chk("rf_valid", 32'(a_ov), 32'd0);
    chk("rf_count", 32'(a_cnt), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
